// File: rtl/div_seq_unit_pkg.sv
// Shared types and constants for the iterative RV32M divide sequencer.
package mdu_pkg;

  typedef enum logic [1:0] {
    DIV_OP  = 2'b00,
    DIVU_OP = 2'b01,
    REM_OP  = 2'b10,
    REMU_OP = 2'b11
  } div_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    DONE = 2'b10
  } div_state_e;

  // Wide enough for any XLEN up to 64; consumers slice to their width.
  localparam logic [63:0] DIV_ZERO_Q = '1;

endpackage

// File: rtl/div_seq_unit_if.sv
// Execute-stage request/response bundle between the pipeline and the divider.
interface div_seq_unit_if
  import mdu_pkg::*;
#(
  parameter int XLEN = 32
);
  // Handshake: a request is taken on a rising edge where start_i && ready_o && !flush_i;
  // the result is presented for exactly the one cycle valid_o is high and then held.
  logic            start_i;
  div_op_e         op_i;
  logic [XLEN-1:0] a_in;
  logic [XLEN-1:0] b_in;
  logic            flush_i;
  logic            ready_o;
  logic            busy_o;
  logic            valid_o;
  logic [XLEN-1:0] result_o;

  modport master (
    output start_i, op_i, a_in, b_in, flush_i,
    input  ready_o, busy_o, valid_o, result_o
  );

  modport slave (
    input  start_i, op_i, a_in, b_in, flush_i,
    output ready_o, busy_o, valid_o, result_o
  );
endinterface

// File: rtl/div_seq_unit.sv
// Radix-2 restoring divider for DIV/DIVU/REM/REMU; divide-by-zero and signed
// overflow are resolved at accept without iterating.
module div_seq_unit
  import mdu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic           clk,
  input  logic           rst_n,
  div_seq_unit_if.slave  bus,
  output div_state_e     state_o
);

  localparam int CW = $clog2(XLEN);

  div_state_e      state_q, state_d;
  div_op_e         op_q, op_d;
  logic [XLEN-1:0] quo_q, quo_d;
  logic [XLEN-1:0] dvs_q, dvs_d;
  logic [XLEN:0]   rem_q, rem_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            negq_q, negq_d;
  logic            negr_q, negr_d;
  logic [XLEN-1:0] result_q, result_d;

  logic            ready;
  logic            accept;
  logic            is_signed;
  logic            a_neg;
  logic            b_neg;
  logic            overflow;
  logic [XLEN:0]   shifted;
  logic            below;
  logic [XLEN-1:0] q_step;
  logic [XLEN:0]   r_step;

  assign ready  = (state_q == IDLE) || (state_q == DONE);
  assign accept = bus.start_i && ready && !bus.flush_i;

  // op_i[0] clear means signed; op_i[1] clear means quotient.
  assign is_signed = !bus.op_i[0];
  assign a_neg     = is_signed && bus.a_in[XLEN-1];
  assign b_neg     = is_signed && bus.b_in[XLEN-1];
  assign overflow  = is_signed && (bus.a_in == {1'b1, {(XLEN-1){1'b0}}}) && (bus.b_in == '1);

  // The compare keeps the borrow exact even when the divisor uses its MSB.
  assign shifted = {rem_q[XLEN-1:0], quo_q[XLEN-1]};
  assign below   = shifted < {1'b0, dvs_q};
  assign q_step  = {quo_q[XLEN-2:0], !below};
  assign r_step  = below ? shifted : (shifted - {1'b0, dvs_q});

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    quo_d    = quo_q;
    dvs_d    = dvs_q;
    rem_d    = rem_q;
    cnt_d    = cnt_q;
    negq_d   = negq_q;
    negr_d   = negr_q;
    result_d = result_q;

    case (state_q)
      CALC: begin
        quo_d = q_step;
        rem_d = r_step;
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == '0) begin
          if (!op_q[1]) result_d = negq_q ? -q_step : q_step;
          else          result_d = negr_q ? -r_step[XLEN-1:0] : r_step[XLEN-1:0];
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (accept) begin
      op_d = bus.op_i;
      if (bus.b_in == '0) begin
        result_d = bus.op_i[1] ? bus.a_in : DIV_ZERO_Q[XLEN-1:0];
        state_d  = DONE;
      end else if (overflow) begin
        result_d = bus.op_i[1] ? '0 : bus.a_in;
        state_d  = DONE;
      end else begin
        quo_d   = a_neg ? -bus.a_in : bus.a_in;
        dvs_d   = b_neg ? -bus.b_in : bus.b_in;
        rem_d   = '0;
        cnt_d   = CW'(XLEN - 1);
        negq_d  = !bus.op_i[1] && (a_neg ^ b_neg);
        negr_d  = bus.op_i[1] && a_neg;
        state_d = CALC;
      end
    end

    if (bus.flush_i) begin
      state_d  = IDLE;
      result_d = result_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      op_q     <= DIV_OP;
      quo_q    <= '0;
      dvs_q    <= '0;
      rem_q    <= '0;
      cnt_q    <= '0;
      negq_q   <= 1'b0;
      negr_q   <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      quo_q    <= quo_d;
      dvs_q    <= dvs_d;
      rem_q    <= rem_d;
      cnt_q    <= cnt_d;
      negq_q   <= negq_d;
      negr_q   <= negr_d;
      result_q <= result_d;
    end
  end

  assign bus.ready_o  = ready;
  assign bus.busy_o   = (state_q == CALC);
  assign bus.valid_o  = (state_q == DONE) && !bus.flush_i;
  assign bus.result_o = result_q;
  assign state_o      = state_q;

endmodule

// File: tb/tb_div_seq_unit.sv
// Self-checking bench for div_seq_unit: reference-model scoreboard plus latency,
// flush, back-to-back and asynchronous reset scenarios.
module tb_div_seq_unit;
  import mdu_pkg::*;

  localparam int W = 32;

  logic       clk;
  logic       rst_n;
  div_state_e state_o;
  int         checks;
  int         errors;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] last_res;

  div_seq_unit_if #(.XLEN(W)) bus ();

  div_seq_unit #(.XLEN(W)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (bus),
    .state_o (state_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [W-1:0] ref_result(input div_op_e op, input logic [W-1:0] a, input logic [W-1:0] b);
    logic signed [W-1:0] sa;
    logic signed [W-1:0] sb;
    logic ovf;
    sa  = a;
    sb  = b;
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    if (b == 0) return (op == REM_OP || op == REMU_OP) ? a : 32'hFFFF_FFFF;
    if (ovf && op == DIV_OP) return a;
    if (ovf && op == REM_OP) return 32'h0;
    case (op)
      DIV_OP:  return sa / sb;
      REM_OP:  return sa % sb;
      DIVU_OP: return a / b;
      default: return a % b;
    endcase
  endfunction

  function automatic int ref_lat(input div_op_e op, input logic [W-1:0] a, input logic [W-1:0] b);
    if (b == 0) return 1;
    if ((op == DIV_OP || op == REM_OP) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return 33;
  endfunction

  // Drives one request at a falling edge and waits (bounded) for valid_o.
  task automatic run_op(input div_op_e op, input logic [W-1:0] a, input logic [W-1:0] b,
                        output bit got, output int cyc, output int bcnt, output logic [W-1:0] res);
    bus.start_i = 1'b1;
    bus.op_i    = op;
    bus.a_in    = a;
    bus.b_in    = b;
    exp_q.push_back(ref_result(op, a, b));
    @(negedge clk);
    bus.start_i = 1'b0;
    bus.op_i    = div_op_e'($urandom_range(0, 3));
    bus.a_in    = $urandom();
    bus.b_in    = $urandom();
    cyc  = 1;
    bcnt = 0;
    while (!bus.valid_o && cyc < 80) begin
      if (bus.busy_o) bcnt++;
      @(negedge clk);
      cyc++;
    end
    got = bus.valid_o;
    res = bus.result_o;
  endtask

  task automatic watch_no_valid(input string nm, input int n);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < n; i++) begin
      if (bus.valid_o) seen = 1'b1;
      @(negedge clk);
    end
    checks++;
    if (seen) begin
      errors++;
      $display("FAIL %s: valid_o observed=1 expected=0 within %0d cycles", nm, n);
    end
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if ({bus.ready_o, bus.busy_o, bus.valid_o} !== 3'b100 || bus.result_o !== 32'h0 || state_o !== IDLE) begin
      errors++;
      $display("FAIL reset_outputs: rdy/busy/vld=%b%b%b res=%h expected 100 res=0", bus.ready_o, bus.busy_o, bus.valid_o, bus.result_o);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // Table-driven directed operations: scoreboard value, table constant, latency, busy window.
  task automatic test_directed();
    div_op_e      ops[15]  = '{DIVU_OP, REMU_OP, DIV_OP, REM_OP, DIV_OP,
                               DIV_OP, DIVU_OP, REM_OP, REMU_OP,
                               DIV_OP, REM_OP, DIVU_OP, REMU_OP, DIV_OP, REM_OP};
    logic [W-1:0] as[15]   = '{100, 100, 32'hFFFF_FF9C, 32'hFFFF_FF9C, 100,
                               32'h1234_5678, 32'h1234_5678, 32'h1234_5678, 32'h1234_5678,
                               32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 7, 7};
    logic [W-1:0] bs[15]   = '{7, 7, 7, 7, 32'hFFFF_FFF9, 0, 0, 0, 0,
                               32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'hFFFF_FFFE};
    logic [W-1:0] want[15] = '{14, 2, 32'hFFFF_FFF2, 32'hFFFF_FFFE, 32'hFFFF_FFF2,
                               32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h1234_5678, 32'h1234_5678,
                               32'h8000_0000, 0, 0, 32'h8000_0000, 32'hFFFF_FFFD, 1};
    int           lats[15] = '{33, 33, 33, 33, 33, 1, 1, 1, 1, 1, 1, 33, 33, 33, 33};
    bit got; int cyc; int bcnt; logic [W-1:0] res; logic [W-1:0] exp;
    for (int i = 0; i < 15; i++) begin
      run_op(ops[i], as[i], bs[i], got, cyc, bcnt, res);
      exp = exp_q.pop_front();
      checks++;
      if (!got) begin
        errors++;
        $display("FAIL directed[%0d] timeout: valid_o=0 expected=1 within 80 cycles", i);
      end else begin
        last_res = exp;
        checks++;
        if (res !== exp || res !== want[i]) begin
          errors++;
          $display("FAIL directed[%0d] result: got %h expected %h", i, res, want[i]);
        end
        checks++;
        if (cyc !== lats[i] || bcnt !== lats[i] - 1) begin
          errors++;
          $display("FAIL directed[%0d] latency: got %0d busy %0d expected %0d busy %0d", i, cyc, bcnt, lats[i], lats[i] - 1);
        end
      end
      @(negedge clk);
    end
  endtask

  task automatic test_random();
    bit got; int cyc; int bcnt; logic [W-1:0] res; logic [W-1:0] exp;
    div_op_e op; logic [W-1:0] a; logic [W-1:0] b;
    for (int i = 0; i < 10; i++) begin
      op = div_op_e'($urandom_range(0, 3));
      a  = $urandom();
      b  = (i % 2 == 0) ? W'($urandom_range(1, 300)) : $urandom();
      if (i % 3 == 0) b = -b;
      run_op(op, a, b, got, cyc, bcnt, res);
      exp = exp_q.pop_front();
      checks++;
      if (!got || res !== exp || cyc !== ref_lat(op, a, b)) begin
        errors++;
        $display("FAIL random[%0d] op=%0d a=%h b=%h: got %h lat %0d expected %h lat %0d", i, op, a, b, res, cyc, exp, ref_lat(op, a, b));
      end
      if (got) last_res = exp;
      @(negedge clk);
    end
  endtask

  task automatic test_flush();
    bit got; int cyc; int bcnt; logic [W-1:0] res; logic [W-1:0] exp;
    bus.start_i = 1'b1; bus.op_i = DIVU_OP; bus.a_in = 32'hFFFF_FFFF; bus.b_in = 3;
    @(negedge clk);
    bus.start_i = 1'b0;
    repeat (9) @(negedge clk);
    bus.flush_i = 1'b1;
    @(negedge clk);
    bus.flush_i = 1'b0;
    #1;
    checks++;
    if (bus.ready_o !== 1'b1 || bus.busy_o !== 1'b0 || bus.valid_o !== 1'b0 || bus.result_o !== last_res) begin
      errors++;
      $display("FAIL flush_calc: rdy=%b busy=%b vld=%b res=%h expected 1 0 0 res=%h", bus.ready_o, bus.busy_o, bus.valid_o, bus.result_o, last_res);
    end
    watch_no_valid("flush_calc_no_valid", 40);
    run_op(DIVU_OP, 9, 3, got, cyc, bcnt, res);
    exp = exp_q.pop_front();
    checks++;
    if (!got || res !== 32'd3 || res !== exp || cyc !== 33) begin
      errors++;
      $display("FAIL flush_then_divu: got %h lat %0d expected 00000003 lat 33", res, cyc);
    end
    last_res = exp;
    @(negedge clk);
    // Flush landing on the DONE cycle masks valid_o and drops a simultaneous start.
    bus.start_i = 1'b1; bus.op_i = DIVU_OP; bus.a_in = 5; bus.b_in = 0;
    @(negedge clk);
    bus.flush_i = 1'b1;
    bus.b_in    = 2;
    #1;
    checks++;
    if (bus.valid_o !== 1'b0) begin
      errors++;
      $display("FAIL flush_done_valid: got %b expected 0", bus.valid_o);
    end
    @(negedge clk);
    bus.flush_i = 1'b0;
    bus.start_i = 1'b0;
    #1;
    checks++;
    if (state_o !== IDLE || bus.result_o !== 32'hFFFF_FFFF) begin
      errors++;
      $display("FAIL flush_done_state: state=%0d res=%h expected state=0 res=ffffffff", state_o, bus.result_o);
    end
    last_res = 32'hFFFF_FFFF;
    watch_no_valid("flush_done_no_valid", 40);
  endtask

  task automatic test_back_to_back();
    div_op_e      ops[3] = '{DIVU_OP, REM_OP, DIV_OP};
    logic [W-1:0] as[3]  = '{100, 32'hFFFF_FF9C, 32'h1234_5678};
    logic [W-1:0] bs[3]  = '{7, 7, 0};
    bit got; int cyc; int bcnt; logic [W-1:0] res; logic [W-1:0] exp;
    for (int i = 0; i < 3; i++) begin
      run_op(ops[i], as[i], bs[i], got, cyc, bcnt, res);
      exp = exp_q.pop_front();
      checks++;
      if (!got || res !== exp || cyc !== ref_lat(ops[i], as[i], bs[i]) || bcnt !== ref_lat(ops[i], as[i], bs[i]) - 1) begin
        errors++;
        $display("FAIL b2b[%0d]: got %h lat %0d busy %0d expected %h lat %0d", i, res, cyc, bcnt, exp, ref_lat(ops[i], as[i], bs[i]));
      end
      if (got) last_res = exp;
    end
    @(negedge clk);
  endtask

  task automatic test_async_reset();
    bit got; int cyc; int bcnt; logic [W-1:0] res; logic [W-1:0] exp;
    bus.start_i = 1'b1; bus.op_i = DIVU_OP; bus.a_in = 1000; bus.b_in = 9;
    @(negedge clk);
    bus.start_i = 1'b0;
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.ready_o, bus.busy_o, bus.valid_o} !== 3'b100 || bus.result_o !== 32'h0 || state_o !== IDLE) begin
      errors++;
      $display("FAIL async_reset: rdy/busy/vld=%b%b%b res=%h expected 100 res=0", bus.ready_o, bus.busy_o, bus.valid_o, bus.result_o);
    end
    @(negedge clk);
    rst_n = 1'b1;
    watch_no_valid("async_reset_no_valid", 40);
    run_op(DIVU_OP, 1000, 9, got, cyc, bcnt, res);
    exp = exp_q.pop_front();
    checks++;
    if (!got || res !== 32'd111 || res !== exp || cyc !== 33) begin
      errors++;
      $display("FAIL after_reset_divu: got %h lat %0d expected 0000006f lat 33", res, cyc);
    end
    @(negedge clk);
  endtask

  initial begin
    checks      = 0;
    errors      = 0;
    last_res    = '0;
    rst_n       = 1'b0;
    bus.start_i = 1'b0;
    bus.op_i    = DIVU_OP;
    bus.a_in    = '0;
    bus.b_in    = '0;
    bus.flush_i = 1'b0;
    test_reset();
    test_directed();
    test_random();
    test_flush();
    test_back_to_back();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
